// File: rtl/cordic_div_linear.sv
// ---------------------------------------------------------------------------
// cordic_div_linear
//   Iterative linear-vectoring CORDIC divider: result = y_in / x_in on signed
//   fixed-point operands with FRAC fractional bits. The divisor is
//   pre-normalised (left-shifted e times) so that quotients beyond |q| < 2 are
//   reachable. The block reports divide-by-zero and saturation, and uses a
//   start/busy/done handshake.
//   Optional: `define CORDIC_DIV_ROUND_EN adds one guard micro-rotation and
//   round-to-nearest in the final step.
//   Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module cordic_div_linear #(
    parameter int WIDTH      = 32,
    parameter int FRAC       = 16,
    parameter int ITERATIONS = 16,
    parameter int EXT_MAX    = WIDTH - FRAC - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] y_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             div_by_zero,
    output logic             overflow
);

`ifdef CORDIC_DIV_ROUND_EN
    localparam int GUARD = 1;
`else
    localparam int GUARD = 0;
`endif
    localparam int ITER_N = ITERATIONS + GUARD;
    localparam int XW     = WIDTH + EXT_MAX;   // normalised divisor never loses bits
    localparam int CW     = XW + 2;            // residual / comparison width
    localparam int ZW     = WIDTH + 2;         // angle (quotient) accumulator
    localparam int QW     = ZW + EXT_MAX;      // quotient after de-normalisation
    localparam int IW     = $clog2(ITER_N + 1);
    localparam int EW     = $clog2(EXT_MAX + 2);

    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [ZW-1:0]    Z_ONE   = ZW'(1) << (FRAC + GUARD);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_NORM  = 2'd1;
    localparam logic [1:0] S_ITER  = 2'd2;
    localparam logic [1:0] S_FINAL = 2'd3;

    logic [1:0]           state;
    logic [XW-1:0]        xa;        // |x|, shifted left during normalisation
    logic signed [CW-1:0] yr;        // |y| during NORM, residual during ITER
    logic signed [ZW-1:0] z;
    logic [IW-1:0]        i;
    logic [EW-1:0]        e;
    logic                 sign;
    logic                 zero_y;
    logic                 ovf_r;
    logic                 dbz_r;

    // Magnitude with the most-negative code clamped to the largest positive.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        if (v == MIN_NEG)
            return MAX_POS;
        else if (v[WIDTH-1])
            return -v;
        else
            return v;
    endfunction

    logic [WIDTH-1:0] x_mag;
    logic [WIDTH-1:0] y_mag;
    logic             need_idle;
    logic             need_norm;
    logic [CW-1:0]    xs;
    logic [ZW-1:0]    zs;
    logic [ZW-1:0]    zc;
    logic [ZW-1:0]    zr;
    logic [QW-1:0]    q;
    logic             sat;
    logic [WIDTH-1:0] mag_q;
    logic [WIDTH-1:0] res_next;
    logic             ovf_next;

    // Operand magnitudes, normalisation look-ahead, micro-rotation steps and
    // the final de-normalise/saturate/sign path.
    always_comb begin
        x_mag     = mag(x_in);
        y_mag     = mag(y_in);
        // Decide the next normalisation step one cycle ahead so NORM costs
        // exactly one cycle per shift.
        need_idle = CW'(y_mag) >= (CW'(x_mag) << 1);
        need_norm = $unsigned(yr) >= (CW'(xa) << 2);
        xs        = CW'(xa) >> i;
        zs        = Z_ONE >> i;
        zc        = z[ZW-1] ? '0 : $unsigned(z);
`ifdef CORDIC_DIV_ROUND_EN
        zr        = (zc + ZW'(1)) >> 1;
`else
        zr        = zc;
`endif
        q         = QW'(zr) << e;
        sat       = dbz_r | ovf_r | (q > QW'(MAX_POS));
        mag_q     = sat ? MAX_POS : q[WIDTH-1:0];
        res_next  = sign ? -mag_q : mag_q;
        ovf_next  = sat & ~dbz_r;
        if (zero_y && !dbz_r) begin
            res_next = '0;
            ovf_next = 1'b0;
        end
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            xa          <= '0;
            yr          <= '0;
            z           <= '0;
            i           <= '0;
            e           <= '0;
            sign        <= 1'b0;
            zero_y      <= 1'b0;
            ovf_r       <= 1'b0;
            dbz_r       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        busy        <= 1'b1;
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                        xa          <= XW'(x_mag);
                        yr          <= CW'(y_mag);
                        sign        <= x_in[WIDTH-1] ^ y_in[WIDTH-1];
                        zero_y      <= (y_in == '0);
                        e           <= '0;
                        z           <= '0;
                        i           <= '0;
                        ovf_r       <= 1'b0;
                        dbz_r       <= 1'b0;
                        if (x_in == '0) begin
                            dbz_r <= 1'b1;
                            state <= S_FINAL;
                        end else if (need_idle) begin
                            if (EXT_MAX == 0) begin
                                ovf_r <= 1'b1;
                                state <= S_FINAL;
                            end else begin
                                state <= S_NORM;
                            end
                        end else begin
                            state <= S_ITER;
                        end
                    end
                end
                S_NORM: begin
                    xa <= xa << 1;
                    e  <= e + EW'(1);
                    if (need_norm) begin
                        // Still out of range but the shift budget is spent.
                        if (int'(e) + 1 == EXT_MAX) begin
                            ovf_r <= 1'b1;
                            state <= S_FINAL;
                        end
                    end else begin
                        state <= S_ITER;
                    end
                end
                S_ITER: begin
                    if (!yr[CW-1]) begin
                        yr <= yr - $signed(xs);
                        z  <= z + $signed(zs);
                    end else begin
                        yr <= yr + $signed(xs);
                        z  <= z - $signed(zs);
                    end
                    i <= i + IW'(1);
                    if (i == IW'(ITER_N - 1))
                        state <= S_FINAL;
                end
                default: begin
                    result      <= res_next;
                    overflow    <= ovf_next;
                    div_by_zero <= dbz_r;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cordic_div_linear.sv
`timescale 1ns/1ps
`default_nettype none

module tb_cordic_div_linear;

`ifdef CORDIC_DIV_ROUND_EN
    localparam int G     = 1;
    localparam int TOL13 = 1;
`else
    localparam int G     = 0;
    localparam int TOL13 = 2;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] x_in;
    logic [31:0] y_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        div_by_zero;
    logic        overflow;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] r_res;
    logic        r_dbz;
    logic        r_ovf;
    logic        r_busy;
    int          r_lat;

    always #5 clk = ~clk;

    cordic_div_linear #(
        .WIDTH(32), .FRAC(16), .ITERATIONS(16), .EXT_MAX(15)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .x_in(x_in), .y_in(y_in),
        .busy(busy), .done(done), .result(result),
        .div_by_zero(div_by_zero), .overflow(overflow)
    );

    function automatic int abs_diff(input logic [31:0] a, input logic [31:0] b);
        longint d;
        d = longint'($signed(a)) - longint'($signed(b));
        return int'(d < 0 ? -d : d);
    endfunction

    // Issue one operation; latency counts edges from the sampling edge to done.
    task automatic run_op(input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        x_in = x; y_in = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        r_lat = 1;
        while (done !== 1'b1 && r_lat < 200) begin
            @(posedge clk); #1;
            r_lat++;
        end
        r_res = result; r_dbz = div_by_zero; r_ovf = overflow; r_busy = busy;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; x_in = '0; y_in = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_checks++; if (done !== 1'b0)   begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
        n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result got=%h exp=0", result); end
        n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dbz got=%b exp=0", div_by_zero); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_quotient();
        logic [31:0] vx [7] = '{32'h0002_0000, 32'h0000_8000, 32'h0003_0000, 32'hFFFD_0000,
                                32'h0003_0000, 32'h0002_0000, 32'hFFFE_0000};
        logic [31:0] vy [7] = '{32'h0001_0000, 32'hFFFD_0000, 32'h0064_0000, 32'hFF9C_0000,
                                32'h0001_0000, 32'h0000_0000, 32'h0000_0000};
        logic [31:0] ve [7] = '{32'h0000_8000, 32'hFFFA_0000, 32'h0021_5555, 32'h0021_5555,
                                32'h0000_5555, 32'h0000_0000, 32'h0000_0000};
        int tol [7] = '{2, 8, 64, 64, TOL13, 0, 0};
        int lat [7] = '{18, 20, 23, 23, 18, 18, 18};
        for (int k = 0; k < 7; k++) begin
            run_op(vx[k], vy[k]);
            n_checks++;
            if ($isunknown(r_res) || abs_diff(r_res, ve[k]) > tol[k]) begin
                n_fail++; $display("FAIL quot_%0d_result got=%h exp=%h tol=%0d", k, r_res, ve[k], tol[k]);
            end
            n_checks++; if (r_dbz !== 1'b0) begin n_fail++; $display("FAIL quot_%0d_dbz got=%b exp=0", k, r_dbz); end
            n_checks++; if (r_ovf !== 1'b0) begin n_fail++; $display("FAIL quot_%0d_ovf got=%b exp=0", k, r_ovf); end
            n_checks++; if (r_lat != lat[k] + G) begin n_fail++; $display("FAIL quot_%0d_latency got=%0d exp=%0d", k, r_lat, lat[k] + G); end
        end
    endtask

    task automatic test_div_by_zero();
        run_op(32'h0000_0000, 32'h0005_0000);
        n_checks++; if (r_res !== 32'h7FFF_FFFF) begin n_fail++; $display("FAIL dbz_result got=%h exp=7fffffff", r_res); end
        n_checks++; if (r_dbz !== 1'b1) begin n_fail++; $display("FAIL dbz_flag got=%b exp=1", r_dbz); end
        n_checks++; if (r_ovf !== 1'b0) begin n_fail++; $display("FAIL dbz_ovf got=%b exp=0", r_ovf); end
        n_checks++; if (r_lat != 2) begin n_fail++; $display("FAIL dbz_latency got=%0d exp=2", r_lat); end
        n_checks++; if (r_busy !== 1'b0) begin n_fail++; $display("FAIL dbz_busy_at_done got=%b exp=0", r_busy); end
        @(posedge clk); #1;
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_pulse got=%b exp=0", done); end
        n_checks++; if (div_by_zero !== 1'b1) begin n_fail++; $display("FAIL dbz_hold got=%b exp=1", div_by_zero); end
    endtask

    task automatic test_overflow();
        run_op(32'h0000_4000, 32'h7530_0000);
        n_checks++; if (r_res !== 32'h7FFF_FFFF) begin n_fail++; $display("FAIL ovf_pos_result got=%h exp=7fffffff", r_res); end
        n_checks++; if (r_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_pos_flag got=%b exp=1", r_ovf); end
        n_checks++; if (r_dbz !== 1'b0) begin n_fail++; $display("FAIL ovf_pos_dbz got=%b exp=0", r_dbz); end
        n_checks++; if (r_lat != 17) begin n_fail++; $display("FAIL ovf_pos_latency got=%0d exp=17", r_lat); end
        run_op(32'h0000_4000, 32'h8AD0_0000);
        n_checks++; if (r_res !== 32'h8000_0001) begin n_fail++; $display("FAIL ovf_neg_result got=%h exp=80000001", r_res); end
        n_checks++; if (r_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_neg_flag got=%b exp=1", r_ovf); end
        n_checks++; if (r_lat != 17) begin n_fail++; $display("FAIL ovf_neg_latency got=%0d exp=17", r_lat); end
    endtask

    task automatic test_back_to_back();
        int n;
        @(negedge clk);
        x_in = 32'h0002_0000; y_in = 32'h0001_0000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 1;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy got=%b exp=1", busy); end
        repeat (4) begin @(posedge clk); #1; n++; end
        @(negedge clk);
        x_in = 32'h0001_0000; y_in = 32'h0007_0000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; n++;
        while (done !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
        n_checks++;
        if ($isunknown(result) || abs_diff(result, 32'h0000_8000) > 2) begin
            n_fail++; $display("FAIL b2b_result got=%h exp=00008000", result);
        end
        n_checks++; if (n != 18 + G) begin n_fail++; $display("FAIL b2b_latency got=%0d exp=%0d", n, 18 + G); end
    endtask

    task automatic test_reset_mid_iter();
        int seen;
        @(negedge clk);
        x_in = 32'h0002_0000; y_in = 32'h0003_0000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #2; rst = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL rmid_busy got=%b exp=0", busy); end
        n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL rmid_result got=%h exp=0", result); end
        n_checks++; if (overflow !== 1'b0 || div_by_zero !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL rmid_flags got=%b%b%b exp=000", overflow, div_by_zero, done);
        end
        @(negedge clk); rst = 1'b0;
        seen = 0;
        repeat (25) begin @(posedge clk); #1; if (done === 1'b1) seen++; end
        n_checks++; if (seen != 0) begin n_fail++; $display("FAIL rmid_no_done got=%0d exp=0", seen); end
        run_op(32'h0000_8000, 32'hFFFD_0000);
        n_checks++;
        if ($isunknown(r_res) || abs_diff(r_res, 32'hFFFA_0000) > 8) begin
            n_fail++; $display("FAIL rmid_after_result got=%h exp=fffa0000", r_res);
        end
        n_checks++; if (r_lat != 20 + G) begin n_fail++; $display("FAIL rmid_after_latency got=%0d exp=%0d", r_lat, 20 + G); end
    endtask

    initial begin
        test_reset();
        test_quotient();
        test_div_by_zero();
        test_overflow();
        test_back_to_back();
        test_reset_mid_iter();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
